ps_framing_guard: RTL and testbench

//  Packet-stream framing guard for a single valid/ready stream with sop/eop markers.
//  - Drops words that arrive outside a packet.
//  - Closes a packet with a forced EOP when a new SOP arrives mid-packet.
//  - Truncates packets longer than MAX_LEN.
//  - Keeps saturating error counters.

---
 rtl/ps_framing_guard.sv | 235 +++++++++++++++++++++++
 tb/tb_ps_framing_guard.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_framing_guard.sv
// ps_framing_guard
// Framing guard for a valid/ready packet stream with sop/eop markers.
// Drops out-of-packet words, closes packets interrupted by a new SOP with a
// forced EOP, truncates packets at MAX_LEN words and keeps saturating error
// counters. A one-word hold register provides lookahead so a forced EOP can
// be attached to the word already waiting to leave.
// Optional feature: define PS_FRAMING_GUARD_ERR_EN to add the o_err output,
// which flags every word whose EOP was forced.
module ps_framing_guard #(
    parameter int WIDTH     = 8,
    parameter int MAX_LEN   = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic [WIDTH-1:0]     i_dat,
    input  logic                 i_val,
    input  logic                 i_sop,
    input  logic                 i_eop,
    output logic                 i_rdy,
    output logic [WIDTH-1:0]     o_dat,
    output logic                 o_val,
    output logic                 o_sop,
    output logic                 o_eop,
    input  logic                 o_rdy,
    input  logic                 clr_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [CNT_WIDTH-1:0] abort_cnt,
    output logic [CNT_WIDTH-1:0] trunc_cnt
`ifdef PS_FRAMING_GUARD_ERR_EN
    ,
    output logic                 o_err
`endif
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t               st_q, st_d;
    logic                 h_val_q, h_val_d;
    logic [WIDTH-1:0]     h_dat_q, h_dat_d;
    logic                 h_sop_q, h_sop_d;
    logic                 h_eop_q, h_eop_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0] abort_cnt_q, abort_cnt_d;
    logic [CNT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d;

    logic             in_pkt_s;
    logic             force_eop_s;
    logic             o_val_s;
    logic             emit_s;
    logic             load_ok_s;
    logic             i_rdy_s;
    logic             acc_s;
    logic             load_s;
    logic             drop_inc_s;
    logic             abort_inc_s;
    logic             trunc_inc_s;
    logic [LEN_W-1:0] len_inc_s;

    // Handshake: presentation of H, lookahead-gated valid and input ready.
    always_comb begin
        in_pkt_s    = (st_q == ST_PKT);
        force_eop_s = in_pkt_s & i_val & i_sop;
        o_val_s     = h_val_q & (h_eop_q | (i_val & in_pkt_s));
        emit_s      = o_val_s & o_rdy;
        load_ok_s   = ~h_val_q | emit_s;
        i_rdy_s     = load_ok_s | (~in_pkt_s & ~i_sop);
        acc_s       = i_val & i_rdy_s;
    end

    // Framing FSM next state and hold-register update.
    always_comb begin
        st_d        = st_q;
        h_dat_d     = h_dat_q;
        h_sop_d     = h_sop_q;
        h_eop_d     = h_eop_q;
        len_d       = len_q;
        load_s      = 1'b0;
        drop_inc_s  = 1'b0;
        abort_inc_s = 1'b0;
        trunc_inc_s = 1'b0;
        len_inc_s   = len_q + LEN_ONE;
        if (emit_s) begin
            h_val_d = 1'b0;
        end else begin
            h_val_d = h_val_q;
        end
        case (st_q)
            ST_IDLE, ST_DROP: begin
                if (acc_s && i_sop) begin
                    load_s  = 1'b1;
                    h_val_d = 1'b1;
                    h_dat_d = i_dat;
                    h_sop_d = 1'b1;
                    h_eop_d = i_eop;
                    len_d   = LEN_ONE;
                    st_d    = i_eop ? ST_IDLE : ST_PKT;
                end else if (acc_s) begin
                    drop_inc_s = 1'b1;
                end else begin
                    st_d = st_q;
                end
            end
            ST_PKT: begin
                if (acc_s && i_sop) begin
                    // Held word leaves this cycle with its EOP forced.
                    abort_inc_s = 1'b1;
                    load_s      = 1'b1;
                    h_val_d     = 1'b1;
                    h_dat_d     = i_dat;
                    h_sop_d     = 1'b1;
                    h_eop_d     = i_eop;
                    len_d       = LEN_ONE;
                    st_d        = i_eop ? ST_IDLE : ST_PKT;
                end else if (acc_s) begin
                    load_s  = 1'b1;
                    h_val_d = 1'b1;
                    h_dat_d = i_dat;
                    h_sop_d = 1'b0;
                    len_d   = len_inc_s;
                    if (i_eop) begin
                        h_eop_d = 1'b1;
                        st_d    = ST_IDLE;
                    end else if (len_inc_s == LEN_MAX) begin
                        h_eop_d     = 1'b1;
                        trunc_inc_s = 1'b1;
                        st_d        = ST_DROP;
                    end else begin
                        h_eop_d = 1'b0;
                    end
                end else begin
                    st_d = ST_PKT;
                end
            end
            default: begin
                st_d    = ST_IDLE;
                h_val_d = 1'b0;
            end
        endcase
    end

    // Error counters: clear wins over increment, increments saturate.
    always_comb begin
        if (clr_cnt) begin
            drop_cnt_d  = CNT_ZERO;
            abort_cnt_d = CNT_ZERO;
            trunc_cnt_d = CNT_ZERO;
        end else begin
            drop_cnt_d  = drop_inc_s  ? sat_inc(drop_cnt_q)  : drop_cnt_q;
            abort_cnt_d = abort_inc_s ? sat_inc(abort_cnt_q) : abort_cnt_q;
            trunc_cnt_d = trunc_inc_s ? sat_inc(trunc_cnt_q) : trunc_cnt_q;
        end
    end

    // State, hold register, word counter and error counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q        <= ST_IDLE;
            h_val_q     <= 1'b0;
            h_dat_q     <= {WIDTH{1'b0}};
            h_sop_q     <= 1'b0;
            h_eop_q     <= 1'b0;
            len_q       <= {LEN_W{1'b0}};
            drop_cnt_q  <= CNT_ZERO;
            abort_cnt_q <= CNT_ZERO;
            trunc_cnt_q <= CNT_ZERO;
        end else begin
            st_q        <= st_d;
            h_val_q     <= h_val_d;
            h_dat_q     <= h_dat_d;
            h_sop_q     <= h_sop_d;
            h_eop_q     <= h_eop_d;
            len_q       <= len_d;
            drop_cnt_q  <= drop_cnt_d;
            abort_cnt_q <= abort_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign i_rdy     = i_rdy_s;
    assign o_val     = o_val_s;
    assign o_dat     = h_dat_q;
    assign o_sop     = h_sop_q;
    assign o_eop     = h_eop_q | force_eop_s;
    assign drop_cnt  = drop_cnt_q;
    assign abort_cnt = abort_cnt_q;
    assign trunc_cnt = trunc_cnt_q;

`ifdef PS_FRAMING_GUARD_ERR_EN
    logic h_err_q, h_err_d;

    // A word loaded into H carries an error only when it was truncated.
    always_comb begin
        if (load_s) begin
            h_err_d = trunc_inc_s;
        end else begin
            h_err_d = h_err_q;
        end
    end

    // Error flag of the held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_err_q <= 1'b0;
        end else begin
            h_err_q <= h_err_d;
        end
    end

    assign o_err = (h_err_q | force_eop_s) & o_val_s;
`endif

endmodule

// File: tb/tb_ps_framing_guard.sv
// Self-checking bench for ps_framing_guard. A packet-level reference model
// turns every accepted input word into the expected output word list and
// error counts; each handshake on the output is compared against it.
module tb_ps_framing_guard;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [7:0] dat;
        bit         sop;
        bit         eop;
        bit         err;
    } wd_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] i_dat;
    logic             i_val, i_sop, i_eop, i_rdy;
    logic [WIDTH-1:0] o_dat;
    logic             o_val, o_sop, o_eop, o_rdy;
    logic             clr_cnt;
    logic [CNT_W-1:0] drop_cnt, abort_cnt, trunc_cnt;
`ifdef PS_FRAMING_GUARD_ERR_EN
    logic             o_err;
`endif

    ps_framing_guard #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .CNT_WIDTH(CNT_W)) dut (
        .reset(reset), .clk(clk),
        .i_dat(i_dat), .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop), .i_rdy(i_rdy),
        .o_dat(o_dat), .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop), .o_rdy(o_rdy),
        .clr_cnt(clr_cnt), .drop_cnt(drop_cnt), .abort_cnt(abort_cnt), .trunc_cnt(trunc_cnt)
`ifdef PS_FRAMING_GUARD_ERR_EN
        , .o_err(o_err)
`endif
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   rdy_pct = 100;
    int   n_emit = 0;
    int   last_wait = 0;
    bit   acc_last = 0;
    bit   prev_stall = 0;
    logic [9:0] prev_word = 10'd0;

    // reference model state
    bit   m_in_pkt = 0;
    int   m_len = 0;
    int   m_drop = 0, m_abort = 0, m_trunc = 0;
    wd_t  m_q[$];

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_pkt = 0; m_len = 0;
        m_drop = 0; m_abort = 0; m_trunc = 0;
        m_q.delete();
        prev_stall = 0;
    endtask

    // Packet rules applied to one accepted input word.
    task automatic model_accept(input logic [7:0] d, input bit s, input bit e);
        wd_t t;
        if (s) begin
            if (m_in_pkt) begin
                t = m_q.pop_back();
                t.eop = 1; t.err = 1;
                m_q.push_back(t);
                m_abort++;
            end
            t.dat = d; t.sop = 1; t.eop = e; t.err = 0;
            m_q.push_back(t);
            m_len = 1;
            m_in_pkt = !e;
        end else if (!m_in_pkt) begin
            m_drop++;
        end else begin
            m_len++;
            t.dat = d; t.sop = 0; t.eop = 1; t.err = 0;
            if (e) begin
                m_in_pkt = 0;
            end else if (m_len == MAX_LEN) begin
                t.err = 1;
                m_trunc++;
                m_in_pkt = 0;
            end else begin
                t.eop = 0;
            end
            m_q.push_back(t);
        end
    endtask

    // One clock: inputs already driven at the negedge, sample mid low phase.
    task automatic cycle();
        wd_t e;
        bit  acc, emi;
        o_rdy = ($urandom_range(0, 99) < rdy_pct);
        #2;
        acc = i_val & i_rdy;
        emi = o_val & o_rdy;
        if (prev_stall) begin
            check("hold_val", {31'd0, o_val}, 32'd1);
            check("hold_word", {22'd0, o_dat, o_sop, o_eop}, {22'd0, prev_word});
        end
        check("drop_cnt", {28'd0, drop_cnt}, sat(m_drop));
        check("abort_cnt", {28'd0, abort_cnt}, sat(m_abort));
        check("trunc_cnt", {28'd0, trunc_cnt}, sat(m_trunc));
        if (acc) model_accept(i_dat, i_sop, i_eop);
        if (clr_cnt) begin
            m_drop = 0; m_abort = 0; m_trunc = 0;
        end
        if (emi) begin
            n_emit++;
            check("emit_expected", {31'd0, m_q.size() != 0}, 32'd1);
            if (m_q.size() != 0) begin
                e = m_q.pop_front();
                check("out_word", {22'd0, o_dat, o_sop, o_eop}, {22'd0, e.dat, e.sop, e.eop});
`ifdef PS_FRAMING_GUARD_ERR_EN
                check("o_err", {31'd0, o_err}, {31'd0, e.err});
`endif
            end
        end
        prev_stall = o_val & ~o_rdy;
        prev_word  = {o_dat, o_sop, o_eop};
        acc_last   = acc;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] d, input bit s, input bit e);
        bit got;
        got = 0;
        i_val = 1'b1; i_dat = d; i_sop = s; i_eop = e;
        for (int w = 0; w < 200; w++) begin
            cycle();
            if (acc_last) begin
                got = 1;
                last_wait = w;
                break;
            end
        end
        check("send_accepted", {31'd0, got}, 32'd1);
        i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        i_val = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic drain();
        int save;
        save = rdy_pct;
        rdy_pct = 100;
        i_val = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_q.size() == 0) break;
            cycle();
        end
        check("drain_empty", m_q.size(), 32'd0);
        rdy_pct = save;
        idle_cycles(1);
    endtask

    task automatic clear_counters();
        clr_cnt = 1'b1;
        idle_cycles(1);
        clr_cnt = 1'b0;
        n_emit = 0;
    endtask

    initial begin
        reset = 1'b1; i_dat = 8'd0; i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
        o_rdy = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_o_val", {31'd0, o_val}, 32'd0);
        check("rst_o_flags", {22'd0, o_dat, o_sop, o_eop}, 32'd0);
        check("rst_cnts", {20'd0, drop_cnt, abort_cnt, trunc_cnt}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_i_rdy", {31'd0, i_rdy}, 32'd1);

        // well-formed 4-word packet
        clear_counters();
        for (int k = 0; k < 4; k++) send_word(8'hA0 + 8'(k), k == 0, k == 3);
        drain();
        check("t1_emits", n_emit, 32'd4);
        check("t1_cnts", {20'd0, drop_cnt, abort_cnt, trunc_cnt}, 32'd0);

        // stray words then a single-word packet
        clear_counters();
        send_word(8'h58, 1'b0, 1'b0);
        check("t2_x_wait", last_wait, 32'd0);
        send_word(8'h59, 1'b0, 1'b0);
        check("t2_y_wait", last_wait, 32'd0);
        send_word(8'h11, 1'b1, 1'b1);
        drain();
        check("t2_drop", {28'd0, drop_cnt}, 32'd2);
        check("t2_emits", n_emit, 32'd1);

        // packet interrupted by a new SOP
        clear_counters();
        send_word(8'hB0, 1'b1, 1'b0);
        send_word(8'hB1, 1'b0, 1'b0);
        send_word(8'hC0, 1'b1, 1'b0);
        send_word(8'hC1, 1'b0, 1'b1);
        drain();
        check("t3_abort", {28'd0, abort_cnt}, 32'd1);
        check("t3_emits", n_emit, 32'd4);

        // over-long packet is truncated
        clear_counters();
        for (int k = 0; k < 6; k++) send_word(8'hD0 + 8'(k), k == 0, k == 5);
        drain();
        check("t4_trunc", {28'd0, trunc_cnt}, 32'd1);
        check("t4_drop", {28'd0, drop_cnt}, 32'd2);
        check("t4_emits", n_emit, 32'd4);

        // random legal traffic under backpressure
        clear_counters();
        rdy_pct = 60;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, MAX_LEN);
            for (int k = 0; k < len; k++) begin
                send_word(8'($urandom), k == 0, k == len - 1);
                if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            end
        end
        drain();
        check("t5_legal_cnts", {20'd0, drop_cnt, abort_cnt, trunc_cnt}, 32'd0);

        // random framing with arbitrary sop/eop flags
        for (int k = 0; k < 150; k++)
            send_word(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        send_word(8'hEE, 1'b1, 1'b1);
        drain();
        rdy_pct = 100;

        // saturation then clear, clear winning over a same-cycle drop
        clear_counters();
        for (int k = 0; k < CNT_MAX + 5; k++) send_word(8'h33, 1'b0, 1'b0);
        idle_cycles(1);
        check("sat_drop", {28'd0, drop_cnt}, CNT_MAX);
        clr_cnt = 1'b1;
        send_word(8'h34, 1'b0, 1'b0);
        clr_cnt = 1'b0;
        idle_cycles(1);
        check("clr_drop", {28'd0, drop_cnt}, 32'd0);

        // reset while H holds a mid-packet word
        send_word(8'hB0, 1'b1, 1'b0);
        send_word(8'hB1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_o_val", {31'd0, o_val}, 32'd0);
        check("mid_rst_word", {22'd0, o_dat, o_sop, o_eop}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_emit = 0;
        send_word(8'h71, 1'b1, 1'b0);
        send_word(8'h72, 1'b0, 1'b1);
        drain();
        check("post_rst_emits", n_emit, 32'd2);
        check("post_rst_cnts", {20'd0, drop_cnt, abort_cnt, trunc_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
